// File: rtl/btn_led_pkg.sv
// Shared constants, types and the round-robin pick helper for the
// button-to-LED toggle arbiter.
package btn_led_pkg;

  localparam int unsigned NUM_BTN                 = 4;
  localparam int unsigned BTN_ID_W                = 2;
  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 50000;
  localparam int unsigned CNT_W                   = 20;

  typedef enum logic {
    LVL_RELEASED = 1'b0,
    LVL_PRESSED  = 1'b1
  } btn_level_e;

  typedef struct packed {
    logic                valid;
    logic [BTN_ID_W-1:0] id;
  } grant_t;

  // First requester found walking ptr, ptr+1, ... with natural mod-4 wrap.
  function automatic grant_t rr_pick(input logic [NUM_BTN-1:0]  req,
                                     input logic [BTN_ID_W-1:0] ptr);
    grant_t              g;
    logic [BTN_ID_W-1:0] idx;
    g = '0;
    for (int unsigned i = 0; i < NUM_BTN; i++) begin
      idx = ptr + BTN_ID_W'(i);
      if (!g.valid && req[idx]) begin
        g.valid = 1'b1;
        g.id    = idx;
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button: 2-flop synchronizer, stability counter and registered
// released->pressed event pulse.
module btn_debounce
  import btn_led_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn_n,
  output logic o_pressed,
  output logic o_press_evt
);

  logic             r_sync1;
  logic             r_sync2;
  logic [CNT_W-1:0] r_cnt;
  btn_level_e       r_level;
  btn_level_e       r_level_d;
  logic             r_press;

  btn_level_e w_sync_level;
  logic       w_differ;
  logic       w_done;

  always_comb begin
    w_sync_level = r_sync2 ? LVL_RELEASED : LVL_PRESSED;
    w_differ     = (w_sync_level != r_level);
    w_done       = w_differ && (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1));
  end

  // Level flips on the edge the count would reach DEBOUNCE_CYCLES.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_cnt     <= '0;
      r_level   <= LVL_RELEASED;
      r_level_d <= LVL_RELEASED;
      r_press   <= 1'b0;
    end else begin
      r_sync1   <= i_btn_n;
      r_sync2   <= r_sync1;
      r_level_d <= r_level;
      r_press   <= (r_level == LVL_PRESSED) && (r_level_d == LVL_RELEASED);
      if (!w_differ) begin
        r_cnt <= '0;
      end else if (w_done) begin
        r_cnt   <= '0;
        r_level <= w_sync_level;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_pressed   = (r_level == LVL_PRESSED);
  assign o_press_evt = r_press;

endmodule

// File: rtl/btn_led_arbiter.sv
// Four debounced buttons; each press toggles its LED via a round-robin
// arbiter that grants at most one pending press per cycle.
module btn_led_arbiter
  import btn_led_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [NUM_BTN-1:0]  i_btn_n,
  input  logic                i_clr_all,
  output logic [NUM_BTN-1:0]  o_led,
  output logic [NUM_BTN-1:0]  o_btn_pressed,
  output logic                o_event_valid,
  output logic [BTN_ID_W-1:0] o_event_id
);

  logic [NUM_BTN-1:0]  w_press;
  logic [NUM_BTN-1:0]  w_pressed;
  grant_t              w_grant;
  logic [NUM_BTN-1:0]  w_grant_oh;
  logic [NUM_BTN-1:0]  w_pending_nxt;

  logic [NUM_BTN-1:0]  r_pending;
  logic [BTN_ID_W-1:0] r_ptr;
  logic [NUM_BTN-1:0]  r_led;
  logic                r_event_valid;
  logic [BTN_ID_W-1:0] r_event_id;

  for (genvar k = 0; k < NUM_BTN; k++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_btn_n     (i_btn_n[k]),
      .o_pressed   (w_pressed[k]),
      .o_press_evt (w_press[k])
    );
  end

  // A new press OR'd after the grant clear keeps pending set when both coincide.
  always_comb begin
    w_grant    = rr_pick(r_pending, r_ptr);
    w_grant_oh = '0;
    if (w_grant.valid) begin
      w_grant_oh[w_grant.id] = 1'b1;
    end
    w_pending_nxt = (r_pending & ~w_grant_oh) | w_press;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pending     <= '0;
      r_ptr         <= '0;
      r_led         <= '0;
      r_event_valid <= 1'b0;
      r_event_id    <= '0;
    end else if (i_clr_all) begin
      r_pending     <= '0;
      r_led         <= '0;
      r_event_valid <= 1'b0;
    end else begin
      r_pending     <= w_pending_nxt;
      r_event_valid <= w_grant.valid;
      if (w_grant.valid) begin
        r_led      <= r_led ^ w_grant_oh;
        r_event_id <= w_grant.id;
        r_ptr      <= w_grant.id + 1'b1;
      end
    end
  end

  assign o_led         = r_led;
  assign o_btn_pressed = w_pressed;
  assign o_event_valid = r_event_valid;
  assign o_event_id    = r_event_id;

endmodule

// File: tb/tb_btn_led_arbiter.sv
// Directed bench for btn_led_arbiter with DEBOUNCE_CYCLES = 4: a vector
// table plus hand-timed sequences for latency, glitch, clear and reset cases.
module tb_btn_led_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] btn_n;
  logic       clr;
  logic [3:0] led;
  logic [3:0] pressed;
  logic       ev_valid;
  logic [1:0] ev_id;

  int unsigned total;
  int unsigned bad;

  btn_led_arbiter #(
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_btn_n       (btn_n),
    .i_clr_all     (clr),
    .o_led         (led),
    .o_btn_pressed (pressed),
    .o_event_valid (ev_valid),
    .o_event_id    (ev_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        do_rst;
    logic [3:0]  btn_n;
    logic        clr;
    int unsigned ticks;
    logic [3:0]  led;
    logic [3:0]  pressed;
    logic        valid;
    logic [1:0]  id;
  } vec_t;

  vec_t tbl [14];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    logic ev_seen;
    logic pr_seen;
    total = 0;
    bad   = 0;

    // press btn1 twice from ptr=1, then 1&3 together from ptr=2
    tbl[0]  = '{1'b0, 4'b1101, 1'b0,  9, 4'b0011, 4'b0010, 1'b1, 2'd1};
    tbl[1]  = '{1'b0, 4'b1111, 1'b0, 12, 4'b0011, 4'b0000, 1'b0, 2'd0};
    tbl[2]  = '{1'b0, 4'b1101, 1'b0,  9, 4'b0001, 4'b0010, 1'b1, 2'd1};
    tbl[3]  = '{1'b0, 4'b1111, 1'b0, 12, 4'b0001, 4'b0000, 1'b0, 2'd0};
    tbl[4]  = '{1'b0, 4'b0101, 1'b0,  9, 4'b1001, 4'b1010, 1'b1, 2'd3};
    tbl[5]  = '{1'b0, 4'b0101, 1'b0,  1, 4'b1011, 4'b1010, 1'b1, 2'd1};
    tbl[6]  = '{1'b0, 4'b0101, 1'b0,  1, 4'b1011, 4'b1010, 1'b0, 2'd0};
    tbl[7]  = '{1'b0, 4'b1111, 1'b0, 12, 4'b1011, 4'b0000, 1'b0, 2'd0};
    // all four from reset: ids 0..3 on consecutive cycles
    tbl[8]  = '{1'b1, 4'b0000, 1'b0,  9, 4'b0001, 4'b1111, 1'b1, 2'd0};
    tbl[9]  = '{1'b0, 4'b0000, 1'b0,  1, 4'b0011, 4'b1111, 1'b1, 2'd1};
    tbl[10] = '{1'b0, 4'b0000, 1'b0,  1, 4'b0111, 4'b1111, 1'b1, 2'd2};
    tbl[11] = '{1'b0, 4'b0000, 1'b0,  1, 4'b1111, 4'b1111, 1'b1, 2'd3};
    tbl[12] = '{1'b0, 4'b0000, 1'b0,  1, 4'b1111, 4'b1111, 1'b0, 2'd0};
    tbl[13] = '{1'b0, 4'b1111, 1'b0, 12, 4'b1111, 4'b0000, 1'b0, 2'd0};

    rst   = 1'b1;
    btn_n = 4'b1111;
    clr   = 1'b0;
    repeat (3) tick();
    chk("rst_led",     {4'h0, led},        8'h00);
    chk("rst_pressed", {4'h0, pressed},    8'h00);
    chk("rst_valid",   {7'h0, ev_valid},   8'h00);
    chk("rst_id",      {6'h0, ev_id},      8'h00);
    rst = 1'b0;
    repeat (3) tick();

    // isolated press on btn0: debounced after 6 edges, event after 9
    btn_n = 4'b1110;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k == 5) chk("a_pressed_early", {4'h0, pressed}, 8'h00);
      if (k == 6) chk("a_pressed",       {4'h0, pressed}, 8'h01);
      if (k == 8) chk("a_valid_early",   {7'h0, ev_valid}, 8'h00);
      if (k == 9) begin
        chk("a_valid", {7'h0, ev_valid}, 8'h01);
        chk("a_id",    {6'h0, ev_id},    8'h00);
        chk("a_led",   {4'h0, led},      8'h01);
      end
      if (k == 10) chk("a_valid_pulse", {7'h0, ev_valid}, 8'h00);
    end
    btn_n = 4'b1111;
    repeat (12) tick();
    chk("a_release_led",     {4'h0, led},     8'h01);
    chk("a_release_pressed", {4'h0, pressed}, 8'h00);

    // 3-cycle glitch on btn2: ignored
    btn_n = 4'b1011;
    repeat (3) tick();
    btn_n   = 4'b1111;
    ev_seen = 1'b0;
    pr_seen = 1'b0;
    for (int k = 0; k < 15; k++) begin
      tick();
      if (ev_valid)   ev_seen = 1'b1;
      if (pressed[2]) pr_seen = 1'b1;
    end
    chk("g_no_event",   {7'h0, ev_seen}, 8'h00);
    chk("g_no_pressed", {7'h0, pr_seen}, 8'h00);
    chk("g_led",        {4'h0, led},     8'h01);

    // 4-cycle pulse on btn2 is just long enough; ptr=1 so btn2 granted
    btn_n = 4'b1011;
    repeat (4) tick();
    btn_n = 4'b1111;
    repeat (4) tick();
    chk("p4_valid_early", {7'h0, ev_valid}, 8'h00);
    tick();
    chk("p4_valid", {7'h0, ev_valid}, 8'h01);
    chk("p4_id",    {6'h0, ev_id},    8'h02);
    chk("p4_led",   {4'h0, led},      8'h05);
    repeat (12) tick();
    chk("p4_released", {4'h0, pressed}, 8'h00);

    // reset mid-debounce of btn0; held button yields one fresh event
    btn_n = 4'b1110;
    repeat (4) tick();
    rst = 1'b1;
    #1;
    chk("r_async_led",     {4'h0, led},      8'h00);
    chk("r_async_valid",   {7'h0, ev_valid}, 8'h00);
    chk("r_async_pressed", {4'h0, pressed},  8'h00);
    repeat (2) tick();
    rst = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k == 5) chk("r_pressed_early", {4'h0, pressed}, 8'h00);
      if (k == 8) chk("r_valid_early",   {7'h0, ev_valid}, 8'h00);
      if (k == 9) begin
        chk("r_valid", {7'h0, ev_valid}, 8'h01);
        chk("r_id",    {6'h0, ev_id},    8'h00);
        chk("r_led",   {4'h0, led},      8'h01);
      end
      if (k == 10) chk("r_valid_pulse", {7'h0, ev_valid}, 8'h00);
    end
    btn_n = 4'b1111;
    repeat (12) tick();

    for (int i = 0; i < 14; i++) begin
      if (tbl[i].do_rst) begin
        btn_n = 4'b1111;
        clr   = 1'b0;
        rst   = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        repeat (2) tick();
      end
      btn_n = tbl[i].btn_n;
      clr   = tbl[i].clr;
      repeat (tbl[i].ticks) tick();
      chk($sformatf("v%0d_led", i),     {4'h0, led},      {4'h0, tbl[i].led});
      chk($sformatf("v%0d_pressed", i), {4'h0, pressed},  {4'h0, tbl[i].pressed});
      chk($sformatf("v%0d_valid", i),   {7'h0, ev_valid}, {7'h0, tbl[i].valid});
      if (tbl[i].valid)
        chk($sformatf("v%0d_id", i), {6'h0, ev_id}, {6'h0, tbl[i].id});
    end

    // LEDs all lit; clear lands on the btn2 press-event cycle
    btn_n = 4'b1011;
    repeat (7) tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("c_led",   {4'h0, led},      8'h00);
    chk("c_valid", {7'h0, ev_valid}, 8'h00);
    ev_seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (ev_valid) ev_seen = 1'b1;
    end
    chk("c_no_event", {7'h0, ev_seen}, 8'h00);
    chk("c_led_hold", {4'h0, led},     8'h00);
    chk("c_pressed",  {4'h0, pressed}, 8'h04);
    btn_n = 4'b1111;
    repeat (12) tick();

    // ptr=0 after granting 3: btn0 and btn3 together -> 0 then 3
    btn_n = 4'b0110;
    repeat (9) tick();
    chk("o_valid0", {7'h0, ev_valid}, 8'h01);
    chk("o_id0",    {6'h0, ev_id},    8'h00);
    chk("o_led0",   {4'h0, led},      8'h01);
    tick();
    chk("o_valid1", {7'h0, ev_valid}, 8'h01);
    chk("o_id1",    {6'h0, ev_id},    8'h03);
    chk("o_led1",   {4'h0, led},      8'h09);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
